// File: rtl/scs8hd_lpflow_pkg.sv
// Shared types and helpers for the level-shift / isolation sequencer.
package scs8hd_lpflow_pkg;

  typedef enum logic [2:0] {
    S_WAKE,
    S_SETTLE,
    S_ON,
    S_ISO,
    S_PWROFF,
    S_OFF
  } state_e;

  // Counter width able to hold the largest of the three cycle limits.
  function automatic int unsigned calc_cnt_w(input int unsigned iso_setup,
                                             input int unsigned settle,
                                             input int unsigned timeout);
    int unsigned m;
    m = iso_setup;
    if (settle > m) m = settle;
    if (timeout > m) m = timeout;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/scs8hd_lpflow_iso_fsm.sv
// Power-down / power-up sequencer: isolation, switch control, power-good handshake.
module scs8hd_lpflow_iso_fsm
  import scs8hd_lpflow_pkg::*;
#(
  parameter int unsigned ISO_SETUP = 2,
  parameter int unsigned SETTLE    = 4,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned CNT_W     = 8
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic sleep_req_i,
  input  logic pwr_good_i,
  output logic capture_o,
  output logic iso_active_o,
  output logic pwr_en_o,
  output logic sleep_ack_o,
  output logic err_o
);

  // Counter holds cycles already spent in the state, so each limit fires on its N-th cycle.
  localparam logic [CNT_W-1:0] IsoLast    = CNT_W'(ISO_SETUP - 1);
  localparam logic [CNT_W-1:0] SettleLast = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] ToLast     = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntMax     = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             err_set;
  logic             iso_q, pwr_en_q, ack_q, err_q;

  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    unique case (state_q)
      S_WAKE: begin
        if (cnt_q == ToLast) err_set = 1'b1;
        if (pwr_good_i) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (!pwr_good_i) state_d = S_WAKE;
        else if (cnt_q == SettleLast) state_d = S_ON;
      end
      S_ON: begin
        if (!pwr_good_i) begin
          state_d = S_WAKE;
          err_set = 1'b1;
        end else if (sleep_req_i) begin
          state_d = S_ISO;
        end
      end
      S_ISO: begin
        if (cnt_q == IsoLast) state_d = S_PWROFF;
      end
      S_PWROFF: begin
        if (cnt_q == ToLast) begin
          err_set = 1'b1;
          state_d = S_OFF;
        end
        if (!pwr_good_i) state_d = S_OFF;
      end
      S_OFF: begin
        if (!sleep_req_i) state_d = S_WAKE;
      end
      default: state_d = S_WAKE;
    endcase
  end

  assign capture_o = (state_q == S_ON) && (state_d == S_ON);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_WAKE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      iso_q    <= 1'b1;
      pwr_en_q <= 1'b1;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= (state_d != state_q) ? '0 : ((cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1);
      err_q    <= err_q | err_set;
      iso_q    <= (state_d != S_ON);
      pwr_en_q <= !((state_d == S_PWROFF) || (state_d == S_OFF));
      ack_q    <= (state_d == S_OFF);
    end
  end

  assign iso_active_o = iso_q;
  assign pwr_en_o     = pwr_en_q;
  assign sleep_ack_o  = ack_q;
  assign err_o        = err_q;

endmodule

// File: rtl/scs8hd_lpflow_lsbuf_iso_seq.sv
// Multi-bit isolating crossing from a switchable domain, with its power sequencer.
module scs8hd_lpflow_lsbuf_iso_seq
  import scs8hd_lpflow_pkg::*;
#(
  parameter int unsigned       WIDTH     = 8,
  parameter logic [WIDTH-1:0]  CLAMP_VAL = '0,
  parameter int unsigned       HOLD_MODE = 0,
  parameter int unsigned       ISO_SETUP = 2,
  parameter int unsigned       SETTLE    = 4,
  parameter int unsigned       TIMEOUT   = 255,
  parameter int unsigned       CNT_W     = calc_cnt_w(ISO_SETUP, SETTLE, TIMEOUT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sleep_req,
  output logic             sleep_ack,
  output logic             pwr_en,
  input  logic             pwr_good,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] x,
  output logic             iso_active,
  output logic             err
);

  logic             capture;
  logic [WIDTH-1:0] x_q, x_d;

  scs8hd_lpflow_iso_fsm #(
    .ISO_SETUP(ISO_SETUP),
    .SETTLE   (SETTLE),
    .TIMEOUT  (TIMEOUT),
    .CNT_W    (CNT_W)
  ) u_fsm (
    .clk_i       (clk),
    .reset_i     (reset),
    .sleep_req_i (sleep_req),
    .pwr_good_i  (pwr_good),
    .capture_o   (capture),
    .iso_active_o(iso_active),
    .pwr_en_o    (pwr_en),
    .sleep_ack_o (sleep_ack),
    .err_o       (err)
  );

  // Source data is only sampled while the domain stays on across the edge.
  always_comb begin
    x_d = x_q;
    if (capture) x_d = a;
    else if (HOLD_MODE == 0) x_d = CLAMP_VAL;
  end

  always_ff @(posedge clk) begin
    if (reset) x_q <= CLAMP_VAL;
    else       x_q <= x_d;
  end

  assign x = x_q;

endmodule

// File: tb/tb_scs8hd_lpflow_lsbuf_iso_seq.sv
// Bench: clamp and hold instances driven in lockstep against a phase/duration model.
module tb_scs8hd_lpflow_lsbuf_iso_seq;

  localparam int unsigned W   = 8;
  localparam int          ISO = 2;
  localparam int          SET = 4;
  localparam int          TO  = 15;

  logic         clk = 1'b0;
  logic         reset, sleep_req, pwr_good;
  logic [W-1:0] a;
  logic [W-1:0] x_c, x_h;
  logic         ack_c, ack_h, en_c, en_h, iso_c, iso_h, err_c, err_h;

  always #5 clk = ~clk;

  scs8hd_lpflow_lsbuf_iso_seq #(
    .WIDTH(W), .CLAMP_VAL(8'h00), .HOLD_MODE(0), .ISO_SETUP(ISO), .SETTLE(SET), .TIMEOUT(TO)
  ) u_clamp (
    .clk(clk), .reset(reset), .sleep_req(sleep_req), .sleep_ack(ack_c), .pwr_en(en_c),
    .pwr_good(pwr_good), .a(a), .x(x_c), .iso_active(iso_c), .err(err_c)
  );

  scs8hd_lpflow_lsbuf_iso_seq #(
    .WIDTH(W), .CLAMP_VAL(8'h00), .HOLD_MODE(1), .ISO_SETUP(ISO), .SETTLE(SET), .TIMEOUT(TO)
  ) u_hold (
    .clk(clk), .reset(reset), .sleep_req(sleep_req), .sleep_ack(ack_h), .pwr_en(en_h),
    .pwr_good(pwr_good), .a(a), .x(x_h), .iso_active(iso_h), .err(err_h)
  );

  int n_checks;
  int n_fail;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: current phase plus the edge index on which it was entered.
  typedef enum int {P_WAKE, P_SETTLE, P_ON, P_ISO, P_PWROFF, P_OFF} phase_e;
  phase_e       m_ph;
  int           m_cyc, m_since;
  logic [W-1:0] m_xc, m_xh;
  logic         m_err;

  function automatic logic exp_en();
    return !((m_ph == P_PWROFF) || (m_ph == P_OFF));
  endfunction

  function automatic void model_edge();
    phase_e nx;
    int     done;
    done = m_cyc - m_since;
    nx   = m_ph;
    if (reset) begin
      m_ph = P_WAKE; m_since = m_cyc; m_xc = '0; m_xh = '0; m_err = 1'b0;
      m_cyc++;
      return;
    end
    case (m_ph)
      P_WAKE: begin
        if (done == TO) m_err = 1'b1;
        if (pwr_good) nx = P_SETTLE;
      end
      P_SETTLE: if (!pwr_good) nx = P_WAKE; else if (done == SET) nx = P_ON;
      P_ON: begin
        if (!pwr_good) begin nx = P_WAKE; m_err = 1'b1; end
        else if (sleep_req) nx = P_ISO;
      end
      P_ISO: if (done == ISO) nx = P_PWROFF;
      P_PWROFF: begin
        if (done == TO) begin m_err = 1'b1; nx = P_OFF; end
        if (!pwr_good) nx = P_OFF;
      end
      P_OFF: if (!sleep_req) nx = P_WAKE;
      default: nx = P_WAKE;
    endcase
    if (m_ph == P_ON && nx == P_ON) begin m_xc = a; m_xh = a; end
    else m_xc = '0;
    if (nx != m_ph) m_since = m_cyc;
    m_ph = nx;
    m_cyc++;
  endfunction

  task automatic step(input logic r, input logic sr, input logic pg, input logic [W-1:0] av);
    reset = r; sleep_req = sr; pwr_good = pg; a = av;
    @(posedge clk);
    model_edge();
    #1;
    check("x_clamp", 32'(x_c), 32'(m_xc));
    check("x_hold", 32'(x_h), 32'(m_xh));
    check("iso_c", 32'(iso_c), 32'(m_ph != P_ON));
    check("iso_h", 32'(iso_h), 32'(m_ph != P_ON));
    check("en_c", 32'(en_c), 32'(exp_en()));
    check("en_h", 32'(en_h), 32'(exp_en()));
    check("ack_c", 32'(ack_c), 32'(m_ph == P_OFF));
    check("ack_h", 32'(ack_h), 32'(m_ph == P_OFF));
    check("err_c", 32'(err_c), 32'(m_err));
    check("err_h", 32'(err_h), 32'(m_err));
  endtask

  initial begin
    logic sr_r, pg_r, r_r;
    n_checks = 0; n_fail = 0;
    m_cyc = 0; m_since = 0; m_ph = P_WAKE; m_xc = '0; m_xh = '0; m_err = 1'b0;

    // Reset and bring-up with a = A5
    step(1, 0, 1, 8'hA5);
    step(1, 0, 1, 8'hA5);
    check("rst_x", 32'(x_c), 32'h00);
    check("rst_iso", 32'(iso_c), 32'd1);
    check("rst_en", 32'(en_c), 32'd1);
    check("rst_ack", 32'(ack_c), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 8'hA5);
      check("bringup_x", 32'(x_c), 32'h00);
    end
    check("on_iso", 32'(iso_c), 32'd0);
    step(0, 0, 1, 8'hA5);
    check("first_x", 32'(x_c), 32'hA5);

    // Tracking with one-cycle latency
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] v;
      v = i[0] ? 8'hC3 : 8'h3C;
      step(0, 0, 1, v);
      check("track_x", 32'(x_c), 32'(v));
    end

    // Power-down
    step(0, 0, 1, 8'h5A);
    step(0, 1, 1, 8'h5A);
    check("clamp_x", 32'(x_c), 32'h00);
    check("hold_x", 32'(x_h), 32'h5A);
    step(0, 1, 1, 8'h5A);
    check("iso_en_hi", 32'(en_c), 32'd1);
    step(0, 1, 1, 8'h5A);
    check("pwroff_en", 32'(en_c), 32'd0);
    step(0, 1, 1, 8'h5A);
    step(0, 1, 1, 8'h5A);
    check("pwroff_ack", 32'(ack_c), 32'd0);
    step(0, 1, 0, 8'h5A);
    check("off_ack", 32'(ack_c), 32'd1);
    check("off_hold_x", 32'(x_h), 32'h5A);

    // Wake, pwr_good arrives 10 cycles later
    step(0, 0, 0, 8'h77);
    check("wake_ack", 32'(ack_c), 32'd0);
    check("wake_en", 32'(en_c), 32'd1);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 8'h77);
    step(0, 0, 1, 8'h77);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 8'h77);
      check("wake_settle_iso", 32'(iso_c), 32'd1);
    end
    step(0, 0, 1, 8'h77);
    check("wake_on_iso", 32'(iso_c), 32'd0);
    check("wake_err", 32'(err_c), 32'd0);

    // Timeout in S_PWROFF with pwr_good stuck high
    step(0, 1, 1, 8'h12);
    step(0, 1, 1, 8'h12);
    step(0, 1, 1, 8'h12);
    for (int i = 0; i < 14; i++) begin
      step(0, 1, 1, 8'h12);
      check("to_off_ack_lo", 32'(ack_c), 32'd0);
    end
    step(0, 1, 1, 8'h12);
    check("to_off_ack", 32'(ack_c), 32'd1);
    check("to_off_err", 32'(err_c), 32'd1);

    // Timeout in S_WAKE with pwr_good stuck low
    step(1, 0, 0, 8'h34);
    for (int i = 0; i < 14; i++) begin
      step(0, 0, 0, 8'h34);
      check("to_wake_err_lo", 32'(err_c), 32'd0);
    end
    step(0, 0, 0, 8'h34);
    check("to_wake_err", 32'(err_c), 32'd1);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 8'h34);
      check("to_wake_iso", 32'(iso_c), 32'd1);
    end

    // Brownout in S_ON
    step(1, 0, 1, 8'h11);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 8'h11);
    check("bo_pre_x", 32'(x_c), 32'h11);
    step(0, 0, 0, 8'h22);
    check("bo_iso", 32'(iso_c), 32'd1);
    check("bo_x", 32'(x_c), 32'h00);
    check("bo_err", 32'(err_c), 32'd1);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 8'h33);
    check("bo_resettle_iso", 32'(iso_c), 32'd0);

    // Reset while in S_PWROFF
    step(0, 1, 1, 8'h44);
    step(0, 1, 1, 8'h44);
    step(0, 1, 1, 8'h44);
    check("mid_en", 32'(en_c), 32'd0);
    step(1, 1, 1, 8'h44);
    check("mid_rst_en", 32'(en_c), 32'd1);
    check("mid_rst_iso", 32'(iso_c), 32'd1);
    check("mid_rst_err", 32'(err_c), 32'd0);
    check("mid_rst_xh", 32'(x_h), 32'h00);

    // Randomized traffic: supply mostly follows pwr_en, with occasional faults
    sr_r = 1'b0;
    step(1, 0, 1, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      r_r = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 23) == 0) sr_r = ~sr_r;
      pg_r = ($urandom_range(0, 31) == 0) ? !exp_en() : exp_en();
      step(r_r, sr_r, pg_r, W'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
